// File: rtl/inject_scheduler.sv
// Round-robin, packet-locked injection scheduler with credit flow control and windowed utilisation count.
// Optional stall watchdog enabled by defining INJECT_WATCHDOG_EN; without it err_stall is tied low.
module inject_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FLIT_W      = 64,
    parameter int CREDITS     = 8,
    parameter int UTIL_WINDOW = 256,
    parameter int WDT_LIMIT   = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_head,
    input  logic [NUM_REQ-1:0]        req_tail,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      inj_valid,
    output logic [FLIT_W-1:0]         inj_flit,
    output logic                      inj_tail,
    input  logic                      credit_ret,
    output logic [7:0]                inj_util,
    output logic                      err_credit,
    output logic                      err_stall
);

    // state    | meaning
    // S_IDLE   | no packet in flight; arbitrate among head flits from rr_ptr
    // S_LOCKED | owner holds the port until its tail flit is accepted

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam int WW = (UTIL_WINDOW > 1) ? $clog2(UTIL_WINDOW) : 1;

    localparam logic [CW-1:0]      CRED_MAX = CW'(CREDITS);
    localparam logic [WW-1:0]      WIN_LAST = WW'(UTIL_WINDOW - 1);
    localparam logic [PW-1:0]      PTR_LAST = PW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t            state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     rr_ptr;
    logic [CW-1:0]     credit_cnt;
    logic [WW-1:0]     win_cnt;
    logic [7:0]        util_cnt;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      grant_idx;
    logic               grant_en;
    logic               accept;
    logic               acc_tail;
    logic [FLIT_W-1:0]  acc_flit;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] x);
        return (x == PTR_LAST) ? '0 : x + 1'b1;
    endfunction

    assign eligible = req_valid & req_head;

    always_comb begin
        int s;
        s         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= NUM_REQ) begin
                s = s - NUM_REQ;
            end
            if (!win_found && eligible[s]) begin
                win_found = 1'b1;
                win_idx   = PW'(s);
            end
        end
    end

    // A credit returned while the counter is empty only becomes usable next cycle.
    assign grant_idx = (state == S_LOCKED) ? owner : win_idx;
    assign grant_en  = (credit_cnt != '0) && ((state == S_LOCKED) || win_found);
    assign req_ready = grant_en ? (ONE_HOT0 << grant_idx) : '0;
    assign accept    = grant_en && req_valid[grant_idx];
    assign acc_tail  = req_tail[grant_idx];
    assign acc_flit  = req_flit[grant_idx*FLIT_W +: FLIT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            inj_valid <= 1'b0;
            inj_flit  <= '0;
            inj_tail  <= 1'b0;
        end else begin
            inj_valid <= accept;
            if (accept) begin
                inj_flit <= acc_flit;
                inj_tail <= acc_tail;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (acc_tail) begin
                            rr_ptr <= inc_wrap(win_idx);
                        end else begin
                            state <= S_LOCKED;
                            owner <= win_idx;
                        end
                    end
                end
                S_LOCKED: begin
                    if (accept && acc_tail) begin
                        state  <= S_IDLE;
                        rr_ptr <= inc_wrap(owner);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt <= CRED_MAX;
            err_credit <= 1'b0;
        end else begin
            case ({accept, credit_ret})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CRED_MAX) begin
                        err_credit <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + 1'b1;
                    end
                end
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // The closing cycle's own flit opens the next window rather than being counted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt  <= '0;
            util_cnt <= '0;
            inj_util <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt  <= '0;
            inj_util <= util_cnt;
            util_cnt <= {7'd0, inj_valid};
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (inj_valid && (util_cnt != 8'hFF)) begin
                util_cnt <= util_cnt + 1'b1;
            end
        end
    end

`ifdef INJECT_WATCHDOG_EN
    localparam int SW = $clog2(WDT_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(WDT_LIMIT);
    localparam logic [SW-1:0] STALL_PRE = SW'(WDT_LIMIT - 1);

    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            err_stall <= 1'b0;
        end else if ((state == S_IDLE) || accept) begin
            stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_PRE) begin
                err_stall <= 1'b1;
            end
        end
    end
`else
    assign err_stall = 1'b0;
`endif

endmodule

// File: tb/tb_inject_scheduler.sv
// Directed bench for inject_scheduler: arbitration, packet lock, credits, utilisation, sticky flags.
module tb_inject_scheduler;

    localparam int NR = 4;
    localparam int FW = 64;
`ifdef INJECT_WATCHDOG_EN
    localparam logic WDT_ON = 1'b1;
`else
    localparam logic WDT_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_head, req_tail;
    logic [NR*FW-1:0] req_flit;
    logic            credit_ret;

    logic [NR-1:0]   req_ready, req_ready_b;
    logic            inj_valid, inj_valid_b;
    logic [FW-1:0]   inj_flit, inj_flit_b;
    logic            inj_tail, inj_tail_b;
    logic [7:0]      inj_util, inj_util_b;
    logic            err_credit, err_credit_b;
    logic            err_stall, err_stall_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inject_scheduler #(.NUM_REQ(NR), .FLIT_W(FW), .CREDITS(8), .UTIL_WINDOW(16), .WDT_LIMIT(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
        .req_flit(req_flit), .req_ready(req_ready), .inj_valid(inj_valid), .inj_flit(inj_flit),
        .inj_tail(inj_tail), .credit_ret(credit_ret), .inj_util(inj_util),
        .err_credit(err_credit), .err_stall(err_stall)
    );

    inject_scheduler #(.NUM_REQ(NR), .FLIT_W(FW), .CREDITS(8), .UTIL_WINDOW(256), .WDT_LIMIT(32)) u_dut_w256 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
        .req_flit(req_flit), .req_ready(req_ready_b), .inj_valid(inj_valid_b), .inj_flit(inj_flit_b),
        .inj_tail(inj_tail_b), .credit_ret(credit_ret), .inj_util(inj_util_b),
        .err_credit(err_credit_b), .err_stall(err_stall_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_flit(input int i, input logic [63:0] v);
        req_flit[i*FW +: FW] = v;
    endtask

    // Leaves the bench at the falling edge of cycle 0 (first cycle out of reset).
    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_head   = '0;
        req_tail   = '0;
        req_flit   = '0;
        credit_ret = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // reset values
        do_reset();
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_inj_valid", inj_valid, 0);
        chk("rst_inj_util", inj_util, 0);
        chk("rst_err_credit", err_credit, 0);
        chk("rst_err_stall", err_stall, 0);

        // all requesters single-flit packets, credit returned every cycle
        req_valid  = '1;
        req_head   = '1;
        req_tail   = '1;
        credit_ret = 1'b1;
        for (int i = 0; i < NR; i++) set_flit(i, 64'hA0 + i);
        for (int k = 0; k < 530; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k < 12) begin
                chk("rr_ready", req_ready, 64'd1 << (k % 4));
                chk("rr_inj_valid", inj_valid, (k > 0) ? 1 : 0);
                if (k > 0) chk("rr_inj_flit", inj_flit, 64'hA0 + ((k - 1) % 4));
            end
            if (k == 20)  chk("util16_first", inj_util, 14);
            if (k == 40)  chk("util16_full", inj_util, 16);
            if (k == 300) chk("util256_first", inj_util_b, 254);
            if (k == 520) chk("util256_sat", inj_util_b, 255);
        end
        chk("rr_no_err_credit", err_credit, 0);

        // packet lock: req 1 sends 3 flits, req 2 and later req 0 wait
        do_reset();
        req_valid = 4'b0110; req_head = 4'b0110; req_tail = 4'b0100;
        set_flit(1, 64'h11); set_flit(2, 64'h22); set_flit(0, 64'h0A);
        #1;
        chk("lock_c0_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = 4'b0111; req_head = 4'b0111; req_tail = 4'b0101; set_flit(1, 64'h12);
        #1;
        chk("lock_c1_ready", req_ready, 4'b0010);
        chk("lock_c1_flit", inj_flit, 64'h11);
        chk("lock_c1_tail", inj_tail, 0);
        @(negedge clk);
        req_head = 4'b0101; req_tail = 4'b0111; set_flit(1, 64'h13);
        #1;
        chk("lock_c2_ready", req_ready, 4'b0010);
        chk("lock_c2_flit", inj_flit, 64'h12);
        @(negedge clk);
        req_valid = 4'b0101;
        #1;
        chk("lock_c3_ready", req_ready, 4'b0100);
        chk("lock_c3_flit", inj_flit, 64'h13);
        chk("lock_c3_tail", inj_tail, 1);
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        chk("lock_c4_ready", req_ready, 4'b0001);
        chk("lock_c4_flit", inj_flit, 64'h22);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("lock_c5_ready", req_ready, 0);
        chk("lock_c5_flit", inj_flit, 64'h0A);
        chk("lock_c5_valid", inj_valid, 1);

        // credit exhaustion and return
        do_reset();
        req_valid = 4'b1000; req_head = 4'b1000; req_tail = 4'b1000; set_flit(3, 64'h33);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("cred_ready", req_ready, (k < 8) ? 4'b1000 : 4'b0000);
            if (k == 8) chk("cred_valid_c8", inj_valid, 1);
            if (k == 9) chk("cred_valid_c9", inj_valid, 0);
        end
        @(negedge clk); credit_ret = 1'b1; #1; chk("cred_c10_ready", req_ready, 0);
        @(negedge clk); credit_ret = 1'b0; #1; chk("cred_c11_ready", req_ready, 4'b1000);
        @(negedge clk); credit_ret = 1'b1; #1; chk("cred_c12_ready", req_ready, 0);
        @(negedge clk); credit_ret = 1'b1; #1; chk("cred_c13_ready", req_ready, 4'b1000);
        @(negedge clk); credit_ret = 1'b0; #1; chk("cred_c14_ready", req_ready, 4'b1000);
        @(negedge clk); req_valid = 4'b0000; credit_ret = 1'b1; #1; chk("cred_c15_ready", req_ready, 0);
        for (int j = 1; j < 8; j++) @(negedge clk);
        @(negedge clk); credit_ret = 1'b0; #1;
        chk("cred_full_no_err", err_credit, 0);
        credit_ret = 1'b1;
        @(negedge clk); credit_ret = 1'b0; #1;
        chk("cred_overflow_err", err_credit, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("cred_err_sticky", err_credit, 1);
        do_reset();
        #1;
        chk("cred_err_cleared", err_credit, 0);

        // 10 flits inside one 16-cycle window
        for (int k = 0; k < 34; k++) begin
            if (k > 0) @(negedge clk);
            req_head   = 4'b0001;
            req_tail   = 4'b0001;
            req_valid  = (k >= 15 && k <= 24) ? 4'b0001 : 4'b0000;
            credit_ret = (k >= 15 && k <= 24);
            #1;
            if (k == 20) chk("util_empty_window", inj_util, 0);
            if (k == 33) chk("util_ten", inj_util, 10);
        end

        // head-only packet then silence: watchdog
        do_reset();
        req_valid = 4'b0100; req_head = 4'b0100; req_tail = 4'b0000; set_flit(2, 64'h66);
        #1;
        chk("wdt_c0_ready", req_ready, 4'b0100);
        for (int k = 1; k < 34; k++) begin
            @(negedge clk);
            req_valid = 4'b0010; req_head = 4'b0010; req_tail = 4'b0010;
            #1;
            if (k == 32) chk("wdt_before_limit", err_stall, 0);
            if (k == 33) begin
                chk("wdt_at_limit", err_stall, WDT_ON);
                chk("wdt_lock_held", req_ready, 4'b0100);
            end
        end

        // reset mid-packet: IDLE again with full credits
        do_reset();
        req_valid = 4'b0010; req_head = 4'b0010; req_tail = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k == 0) chk("midrst_err_stall", err_stall, 0);
            chk("midrst_ready", req_ready, (k < 8) ? 4'b0010 : 4'b0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
